// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - receiver FSM state encoding
//   - parity mode encoding (matches the PARITY parameter of uart_rx)
//   - data width of one character
//   - small bit-level helpers (majority vote, parity check)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 32'sd8;

  // Parity modes, compared directly against the integer PARITY parameter
  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // 2-of-3 majority, used to reject single-sample glitches around mid-bit
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Returns 1 when the received parity bit disagrees with the data for the mode
  function automatic logic parity_bad(input logic [UART_DATA_BITS-1:0] data,
                                      input logic                      par_bit,
                                      input int                        mode);
    logic sum_s;
    sum_s = (^data) ^ par_bit;
    case (mode)
      PAR_ODD:  parity_bad = ~sum_s;
      PAR_EVEN: parity_bad = sum_s;
      default:  parity_bad = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Line conditioning and bit timing for uart_rx.
//   clk, rst      : clock, asynchronous active-low reset
//   ce            : oversample tick (one clk wide)
//   rx            : asynchronous serial line, idle high
//   run           : 1 while the receiver will be inside a frame next cycle;
//                   0 parks the tick counter at 0
//   rx_s          : synchronised line
//   sample_valid  : one-clk strobe on the ce cycle of the decision tick (M+1)
//   bit_value     : majority vote of rx_s at ticks M-1, M, M+1
//   bit_end       : one-clk strobe on the ce cycle of the last tick of a bit
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic rx,
  input  logic run,
  output logic rx_s,
  output logic sample_valid,
  output logic bit_value,
  output logic bit_end
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_VOTE_A = TW'(MID - 1);
  localparam logic [TW-1:0] T_VOTE_B = TW'(MID);
  localparam logic [TW-1:0] T_DEC    = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_ONE    = {{(TW-1){1'b0}}, 1'b1};

  logic          rx_meta_r;
  logic          rx_sync_r;
  logic [TW-1:0] tick_r;
  logic          vote_a_r;
  logic          vote_b_r;

  assign rx_s = rx_sync_r;

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Tick counter: the ce cycle that detects a start edge is tick 0 of the start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_r <= {TW{1'b0}};
    end else if (!run) begin
      tick_r <= {TW{1'b0}};
    end else if (ce) begin
      tick_r <= (tick_r == T_LAST) ? {TW{1'b0}} : tick_r + T_ONE;
    end else begin
      tick_r <= tick_r;
    end
  end

  // First two of the three vote samples; the third is taken live at the decision tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_a_r <= 1'b1;
      vote_b_r <= 1'b1;
    end else begin
      if (ce && (tick_r == T_VOTE_A)) begin
        vote_a_r <= rx_sync_r;
      end else begin
        vote_a_r <= vote_a_r;
      end
      if (ce && (tick_r == T_VOTE_B)) begin
        vote_b_r <= rx_sync_r;
      end else begin
        vote_b_r <= vote_b_r;
      end
    end
  end

  // Decision strobes; tick_r is parked at 0 outside a frame so these stay low in idle
  always_comb begin
    sample_valid = ce & (tick_r == T_DEC);
    bit_end      = ce & (tick_r == T_LAST);
    bit_value    = majority3(vote_a_r, vote_b_r, rx_sync_r);
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receive front end: recovers 8N1 / 8O1 / 8E1 frames from an oversampled
// asynchronous line and presents each good byte with a one-clk strobe.
// Parameters:
//   OVERSAMPLE : ce ticks per bit period (even, >= 8)
//   PARITY     : PAR_NONE (0), PAR_ODD (1), PAR_EVEN (2)
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   ce         : oversample tick, one clk wide
//   rx         : asynchronous serial line, idle high
//   rx_byte    : last good received byte (named rx_byte because 'byte' is a
//                reserved word); holds between frames
//   byte_dv    : one-clk pulse, rx_byte valid this cycle
//   frame_err  : one-clk pulse, stop bit sampled low
//   parity_err : one-clk pulse, parity mismatch with a good stop bit
//   busy       : high from start-bit detect until return to idle
// The stop bit is resolved at its mid-point, so the receiver is back in idle
// half a bit early and can catch a start edge that follows immediately.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      byte_dv,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      busy
);

  localparam int W  = UART_DATA_BITS;
  localparam int CW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST = CW'(UART_DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic          rx_s;
  logic          sample_valid_s;
  logic          bit_value_s;
  logic          bit_end_s;
  logic          run_s;

  uart_state_e   state_r;
  uart_state_e   state_nxt_s;
  logic [W-1:0]  shift_r;
  logic [W-1:0]  shift_nxt_s;
  logic [CW-1:0] bit_cnt_r;
  logic [CW-1:0] bit_cnt_nxt_s;
  logic          par_bad_r;
  logic          par_bad_nxt_s;
  logic [W-1:0]  byte_r;
  logic [W-1:0]  byte_nxt_s;
  logic          dv_r;
  logic          dv_nxt_s;
  logic          ferr_r;
  logic          ferr_nxt_s;
  logic          perr_r;
  logic          perr_nxt_s;
  logic          busy_r;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .rx           (rx),
    .run          (run_s),
    .rx_s         (rx_s),
    .sample_valid (sample_valid_s),
    .bit_value    (bit_value_s),
    .bit_end      (bit_end_s)
  );

  // The tick counter keeps running only while the next state is inside a frame
  assign run_s = (state_nxt_s != ST_IDLE);

  // Receiver FSM next-state and datapath next values; everything holds when ce is low
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    par_bad_nxt_s = par_bad_r;
    byte_nxt_s    = byte_r;
    dv_nxt_s      = 1'b0;
    ferr_nxt_s    = 1'b0;
    perr_nxt_s    = 1'b0;
    if (ce) begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_nxt_s   = ST_START;
            bit_cnt_nxt_s = {CW{1'b0}};
            par_bad_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_START: begin
          // A start bit that votes high at mid-bit was a glitch
          if (sample_valid_s && bit_value_s) begin
            state_nxt_s = ST_IDLE;
          end else if (bit_end_s) begin
            state_nxt_s = ST_DATA;
          end else begin
            state_nxt_s = ST_START;
          end
        end
        ST_DATA: begin
          if (sample_valid_s) begin
            shift_nxt_s = {bit_value_s, shift_r[W-1:1]};
          end else begin
            shift_nxt_s = shift_r;
          end
          if (bit_end_s) begin
            if (bit_cnt_r == BIT_LAST) begin
              state_nxt_s = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
            end
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (sample_valid_s) begin
            par_bad_nxt_s = parity_bad(shift_r, bit_value_s, PARITY);
          end else begin
            par_bad_nxt_s = par_bad_r;
          end
          if (bit_end_s) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_PARITY;
          end
        end
        ST_STOP: begin
          // Resolved at mid-bit; a framing error masks any parity result
          if (sample_valid_s) begin
            if (bit_value_s) begin
              state_nxt_s = ST_IDLE;
              if (par_bad_r) begin
                perr_nxt_s = 1'b1;
              end else begin
                dv_nxt_s   = 1'b1;
                byte_nxt_s = shift_r;
              end
            end else begin
              state_nxt_s = ST_BREAK;
              ferr_nxt_s  = 1'b1;
            end
          end else begin
            state_nxt_s = ST_STOP;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BREAK;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= {W{1'b0}};
      bit_cnt_r <= {CW{1'b0}};
      par_bad_r <= 1'b0;
      byte_r    <= {W{1'b0}};
      dv_r      <= 1'b0;
      ferr_r    <= 1'b0;
      perr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      par_bad_r <= par_bad_nxt_s;
      byte_r    <= byte_nxt_s;
      dv_r      <= dv_nxt_s;
      ferr_r    <= ferr_nxt_s;
      perr_r    <= perr_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign rx_byte    = byte_r;
  assign byte_dv    = dv_r;
  assign frame_err  = ferr_r;
  assign parity_err = perr_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Three receivers (no parity, odd, even) share clk/ce/rst; each has its own rx
// line. Frames are driven one at a time; every expected pulse is queued when
// its frame is driven and matched by a monitor when any receiver pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_PERR = 2'd2;

  typedef struct packed {
    logic [1:0] dut;
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  typedef struct packed {
    logic [1:0] dut;
    logic [7:0] data;
    logic       flip;
    logic       stop;
    logic [1:0] exp_kind;
    logic [7:0] exp_byte;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       rx_v     [3];
  logic [7:0] byte_w   [3];
  logic       dv_w     [3];
  logic       ferr_w   [3];
  logic       perr_w   [3];
  logic       busy_w   [3];

  int         n_checks = 0;
  int         n_errors = 0;
  int         tick_cnt = 0;
  int         exp_dec_tick = 0;
  logic       ce_q = 1'b0;
  logic [2:0] prev_pulse [3];
  logic [15:0] word_r = 16'h0000;
  ev_t        exp_q [$];
  vec_t       vecs [12];

  uart_rx #(.OVERSAMPLE(OS), .PARITY(PAR_NONE)) u_dut_n (
    .clk(clk), .rst(rst), .ce(ce), .rx(rx_v[0]), .rx_byte(byte_w[0]), .byte_dv(dv_w[0]),
    .frame_err(ferr_w[0]), .parity_err(perr_w[0]), .busy(busy_w[0]));
  uart_rx #(.OVERSAMPLE(OS), .PARITY(PAR_ODD)) u_dut_o (
    .clk(clk), .rst(rst), .ce(ce), .rx(rx_v[1]), .rx_byte(byte_w[1]), .byte_dv(dv_w[1]),
    .frame_err(ferr_w[1]), .parity_err(perr_w[1]), .busy(busy_w[1]));
  uart_rx #(.OVERSAMPLE(OS), .PARITY(PAR_EVEN)) u_dut_e (
    .clk(clk), .rst(rst), .ce(ce), .rx(rx_v[2]), .rx_byte(byte_w[2]), .byte_dv(dv_w[2]),
    .frame_err(ferr_w[2]), .parity_err(perr_w[2]), .busy(busy_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ce: one clk in every four, changed on the falling edge
  initial begin
    int div;
    div = 0;
    ce  = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      ce  = (div == 0);
    end
  end

  always @(posedge clk) begin
    ce_q <= ce;
    if (ce) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pulse_vec(input int i);
    return {perr_w[i], ferr_w[i], dv_w[i]};
  endfunction

  // Scoreboard monitor: every pulse must be the next queued event, one-hot, one clk wide,
  // directly after the ce cycle that carries the stop-bit decision tick
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pulse_vec(i) != 3'b000) begin
        check("pulse_onehot", $countones(pulse_vec(i)), 32'd1);
        check("pulse_width", {29'd0, prev_pulse[i]}, 32'd0);
        check("pulse_after_ce", {31'd0, ce_q}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, pulse_vec(i)}, 32'd0);
        end else begin
          check("event_dut", i, {30'd0, exp_q[0].dut});
          check("event_kind", {29'd0, pulse_vec(i)}, {29'd0, 3'b001 << exp_q[0].kind});
          check("event_byte", {24'd0, byte_w[i]}, {24'd0, exp_q[0].data});
          check("decision_tick", tick_cnt, exp_dec_tick);
          void'(exp_q.pop_front());
        end
        if (i == 0 && dv_w[0]) word_r <= {byte_w[0], word_r[15:8]};
      end
      prev_pulse[i] <= pulse_vec(i);
    end
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (ce !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input int d_i, input logic b, input int n);
    rx_v[d_i] = b;
    wait_ticks(n);
  endtask

  // dut index doubles as parity mode: 0 none, 1 odd, 2 even
  task automatic send_frame(input int d_i, input logic [7:0] d, input logic flip,
                            input logic stop, input int stop_len);
    logic p;
    send_bit(d_i, 1'b0, OS);
    for (int b = 0; b < 8; b++) send_bit(d_i, d[b], OS);
    if (d_i != 0) begin
      p = (d_i == 1) ? ~(^d) : (^d);
      send_bit(d_i, p ^ flip, OS);
    end
    exp_dec_tick = tick_cnt + OS / 2 + 2;
    send_bit(d_i, stop, stop_len);
  endtask

  task automatic push_ev(input int d_i, input logic [1:0] kind, input logic [7:0] data);
    exp_q.push_back({d_i[1:0], kind, data});
  endtask

  task automatic idle_and_check(input int d_i, input logic [7:0] exp_byte);
    rx_v[d_i] = 1'b1;
    wait_ticks(2 * OS);
    check("event_missing", exp_q.size(), 32'd0);
    check("busy_idle", {31'd0, busy_w[d_i]}, 32'd0);
    check("byte_held", {24'd0, byte_w[d_i]}, {24'd0, exp_byte});
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_byte"}, {24'd0, byte_w[i]}, 32'd0);
      check({tag, "_pulses"}, {29'd0, pulse_vec(i)}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy_w[i]}, 32'd0);
    end
  endtask

  initial begin
    // {dut, data, parity flip, stop bit, expected event, expected byte at event}
    vecs[0]  = {2'd0, 8'hA5, 1'b0, 1'b1, K_BYTE, 8'hA5};
    vecs[1]  = {2'd2, 8'hA5, 1'b0, 1'b1, K_BYTE, 8'hA5};
    vecs[2]  = {2'd2, 8'h3C, 1'b1, 1'b1, K_PERR, 8'hA5};
    vecs[3]  = {2'd2, 8'h3C, 1'b0, 1'b1, K_BYTE, 8'h3C};
    vecs[4]  = {2'd1, 8'h3C, 1'b0, 1'b1, K_BYTE, 8'h3C};
    vecs[5]  = {2'd1, 8'h01, 1'b1, 1'b1, K_PERR, 8'h3C};
    vecs[6]  = {2'd1, 8'h80, 1'b0, 1'b1, K_BYTE, 8'h80};
    vecs[7]  = {2'd2, 8'h81, 1'b1, 1'b0, K_FERR, 8'h3C};
    vecs[8]  = {2'd0, 8'h00, 1'b0, 1'b1, K_BYTE, 8'h00};
    vecs[9]  = {2'd0, 8'hFF, 1'b0, 1'b1, K_BYTE, 8'hFF};
    vecs[10] = {2'd1, 8'hFF, 1'b1, 1'b1, K_PERR, 8'h80};
    vecs[11] = {2'd2, 8'hE7, 1'b0, 1'b1, K_BYTE, 8'hE7};

    rst = 1'b0;
    for (int i = 0; i < 3; i++) rx_v[i] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(4);

    for (int v = 0; v < 12; v++) begin
      push_ev(int'(vecs[v].dut), vecs[v].exp_kind, vecs[v].exp_byte);
      send_frame(int'(vecs[v].dut), vecs[v].data, vecs[v].flip, vecs[v].stop, OS);
      if (!vecs[v].stop) send_bit(int'(vecs[v].dut), 1'b0, 2 * OS);
      idle_and_check(int'(vecs[v].dut), vecs[v].exp_byte);
    end

    // False start: low for 4 ticks; busy must be gone right after decision tick M+1
    rx_v[0] = 1'b0;
    wait_ticks(4);
    check("false_start_busy_hi", {31'd0, busy_w[0]}, 32'd1);
    rx_v[0] = 1'b1;
    wait_ticks(OS / 2 - 2);
    check("false_start_busy_lo", {31'd0, busy_w[0]}, 32'd0);
    wait_ticks(OS);
    push_ev(0, K_BYTE, 8'h5A);
    send_frame(0, 8'h5A, 1'b0, 1'b1, OS);
    idle_and_check(0, 8'h5A);

    // Framing error followed by a 30-bit break, then a normal frame
    push_ev(0, K_FERR, 8'h5A);
    send_frame(0, 8'h81, 1'b0, 1'b0, OS);
    for (int b = 0; b < 30; b++) begin
      send_bit(0, 1'b0, OS);
      check("break_busy", {31'd0, busy_w[0]}, 32'd1);
    end
    idle_and_check(0, 8'h5A);
    push_ev(0, K_BYTE, 8'h7E);
    send_frame(0, 8'h7E, 1'b0, 1'b1, OS);
    idle_and_check(0, 8'h7E);

    // Back-to-back frames, packed LSB byte first into a 16-bit word
    push_ev(0, K_BYTE, 8'h12);
    push_ev(0, K_BYTE, 8'h34);
    send_frame(0, 8'h12, 1'b0, 1'b1, OS);
    send_frame(0, 8'h34, 1'b0, 1'b1, OS);
    idle_and_check(0, 8'h34);
    check("word_3412", {16'd0, word_r}, 32'h0000_3412);

    // Shortened stop bit: next start edge right after the stop mid-point decision
    push_ev(0, K_BYTE, 8'h56);
    push_ev(0, K_BYTE, 8'h78);
    send_frame(0, 8'h56, 1'b0, 1'b1, OS / 2 + 2);
    send_frame(0, 8'h78, 1'b0, 1'b1, OS);
    idle_and_check(0, 8'h78);
    check("word_7856", {16'd0, word_r}, 32'h0000_7856);

    // Reset in the middle of the data bits of 0xFF
    send_bit(0, 1'b0, OS);
    send_bit(0, 1'b1, 3 * OS + 5);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    rx_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(OS);
    check("after_reset_byte", {24'd0, byte_w[0]}, 32'd0);
    push_ev(0, K_BYTE, 8'h0F);
    send_frame(0, 8'h0F, 1'b0, 1'b1, OS);
    idle_and_check(0, 8'h0F);

    check("queue_empty_end", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive front end of the UART path.
- Oversamples the asynchronous rx line, recovers 8N1/8E1/8O1 frames and presents each received byte with a single-cycle valid strobe.
- Its byte/byte_dv outputs drive the byte-to-word packing stage directly. That stage's ce is tied high, so this block's strobe is one clk wide.

Parameters:
- OVERSAMPLE, 16, ce ticks per bit period; even value, minimum 8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  oversample tick, one clk wide, OVERSAMPLE per bit period.
- rx  in  1  asynchronous serial line, idle high.
- byte  out  8  last good received byte, LSB-first assembled.
- byte_dv  out  1  one-clk pulse: byte is valid this cycle.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- parity_err  out  1  one-clk pulse: parity mismatch.
- busy  out  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset (rst low, async): byte = 0x00; byte_dv, frame_err, parity_err and busy = 0; FSM in IDLE; synchroniser flops = 1; counters = 0.
- rx passes through a 2-flop synchroniser (rx_s) before any use.
- Tick counter counts ce pulses 0..OVERSAMPLE-1. The FSM advances only on clk cycles with ce = 1.
- Bit value is a majority vote of rx_s at ticks M-1, M and M+1, where M = OVERSAMPLE/2 (7, 8, 9 for the default). The decision is taken at tick M+1.
- FSM states and transitions:
  - IDLE: busy = 0. On ce with rx_s = 0, go to START with tick = 0.
  - START: at the decision tick, vote = 1 means false start → IDLE, no outputs. Vote = 0 → DATA at the end of the bit period.
  - DATA: 8 bits, LSB first, shifted into a shift register. Bit counter 0..7. After bit 7 → PARITY if PARITY != 0, else STOP.
  - PARITY: voted bit compared against XOR of the data. Odd: data^p must be 1. Even: data^p must be 0. Result latched → STOP.
  - STOP: at the decision tick (not at the end of the period):
    - vote = 1 and no parity error: byte <= shift register, byte_dv = 1 on the next clk; → IDLE.
    - vote = 1 with parity error: parity_err pulses, byte unchanged, no byte_dv; → IDLE.
    - vote = 0: frame_err pulses, byte unchanged, no byte_dv; → BREAK. Parity is not reported on a framing error.
  - BREAK: busy stays 1; wait for rx_s = 1 on a ce tick, then → IDLE.
- Early return from STOP at mid-bit gives half a bit of resync margin for the next start edge.
- Latency: byte_dv is asserted exactly 1 clk after the ce cycle carrying the stop-bit decision tick.
- byte_dv, frame_err and parity_err are mutually exclusive and never longer than 1 clk. At most one of them per frame.
- byte holds its value between frames.
- ce = 0 freezes the FSM and counters. Output pulses still deassert after 1 clk.
- Back-to-back frames (start edge immediately after the stop-bit mid-point) must be received without loss.
- Asserting rst mid-frame aborts the frame silently: no pulse, outputs at reset values.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Parity encoding constants: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - Data width constant UART_DATA_BITS = 8.
- One natural sub-module: uart_rx_sampler. It contains the 2-flop synchroniser, the tick counter and the 3-sample majority vote, and outputs rx_s plus a sample_valid/bit_value pair at the decision tick.
- The FSM and output registers stay in uart_rx.

Test Plan:
- PARITY = 0, ce every 4 clk, send 0xA5 as 8N1 → single byte_dv pulse, byte = 0xA5, no error pulses, busy back to 0.
- PARITY = 2, send 0x3C with the parity bit forced to 1 → parity_err pulse, no byte_dv, byte keeps its previous value (0xA5).
- rx low for 4 ticks only, then high → no outputs, busy returns to 0 by tick M+1, and a following 0x5A frame is received correctly.
- Send 0x81 with stop bit 0, then rx held low 30 bit periods → frame_err pulse once, busy = 1 for the whole break. After rx goes high, frame 0x7E yields byte_dv with byte = 0x7E.
- Back-to-back 0x12, 0x34 with the start bit immediately following the stop bit → two byte_dv pulses. The downstream word stage presents word = 0x3412 with word_dv.
- Assert rst low mid DATA of frame 0xFF → all outputs 0 immediately. After release, the next frame 0x0F is received correctly with no spurious pulse.
